// File: rtl/sum_of_evens_seq.sv
// Iterative sum of even integers in [0,N], one term per clock under start/done handshake.
// Latency: done pulses k+2 cycles after the accepted start edge (k = floor(N/2)); start ignored while busy.
module sum_of_evens_seq #(
    parameter int N_W = 4,
    parameter int S_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [N_W-1:0] i_n,
    output logic           o_busy,
    output logic           o_done,
    output logic [S_W-1:0] o_s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [S_W-1:0] STEP = S_W'(2);

    state_t         r_state;
    logic [N_W-1:0] r_n;
    logic [S_W-1:0] r_acc;
    logic [S_W-1:0] r_i;
    logic [S_W-1:0] r_s;
    logic           r_done;
    logic           r_busy;

    // Operand zero-extended so the loop bound compare never truncates i.
    logic [S_W-1:0] w_n_ext;
    logic           w_more;

    assign w_n_ext = S_W'(r_n);
    assign w_more  = (r_i <= w_n_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_acc   <= '0;
            r_i     <= '0;
            r_s     <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_n     <= i_n;
                        r_acc   <= '0;
                        r_i     <= STEP;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_done <= 1'b0;
                    if (w_more) begin
                        r_acc <= r_acc + r_i;
                        r_i   <= r_i + STEP;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_s     <= r_acc;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_s    = r_s;

endmodule

// File: tb/tb_sum_of_evens_seq.sv
// Bench for sum_of_evens_seq: directed cases plus random N against closed-form k*(k+1),
// with a queue-based scoreboard checking result and done timing.
module tb_sum_of_evens_seq;

    localparam int N_W = 4;
    localparam int S_W = 7;

    logic           clk;
    logic           rst_n;
    logic           i_start;
    logic [N_W-1:0] i_n;
    logic           o_busy;
    logic           o_done;
    logic [S_W-1:0] o_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_s[$];
    int exp_cyc[$];

    int sweep_tab[16] = '{0, 0, 2, 2, 6, 6, 12, 12, 20, 20, 30, 30, 42, 42, 56, 56};

    sum_of_evens_seq #(.N_W(N_W), .S_W(S_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_n     (i_n),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_s     (o_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int closed_form(input int n);
        int k;
        k = n / 2;
        return k * (k + 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (exp_s.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done with S=%0d expected no done (cycle %0d)", o_s, cyc);
            end else begin
                check("result_S", int'(o_s), exp_s.pop_front());
                check("done_cycle", cyc, exp_cyc.pop_front());
            end
        end
    end

    // One operation: issue start, expect S and done timing, count busy cycles.
    // poke_mid re-pulses start with a different N while the block is running.
    task automatic run_op(input int n, input int s_exp, input bit poke_mid);
        int a;
        int k;
        int busy_cnt;
        k = n / 2;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_n     = N_W'(n);
        @(posedge clk); #1;
        a       = cyc;
        i_start = 1'b0;
        exp_s.push_back(s_exp);
        exp_cyc.push_back(a + k + 2);
        busy_cnt = 0;
        for (int c = 0; c < k + 4; c++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (poke_mid && c == 1) begin
                i_n     = N_W'(3);
                i_start = 1'b1;
            end else if (poke_mid && c == 2) begin
                i_start = 1'b0;
            end
        end
        // Busy spans the k+1 RUN cycles plus the DONE cycle.
        check("busy_cycles", busy_cnt, k + 2);
    endtask

    // Start held high: back-to-back runs with a single IDLE cycle between them.
    task automatic run_held(input int n, input int reps);
        int a;
        int k;
        k = n / 2;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_n     = N_W'(n);
        @(posedge clk); #1;
        a = cyc;
        for (int j = 0; j < reps; j++) begin
            exp_s.push_back(closed_form(n));
            exp_cyc.push_back(a + j * (k + 3) + k + 2);
        end
        repeat ((reps - 1) * (k + 3) + k + 2) @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (k + 4) @(posedge clk);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_n     = '0;
        repeat (2) @(negedge clk);
        check("reset_S", int'(o_s), 0);
        check("reset_done", int'(o_done), 0);
        check("reset_busy", int'(o_busy), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) run_op(v, sweep_tab[v], 1'b0);

        run_op(14, 56, 1'b0);
        run_op(10, 30, 1'b1);

        // Reset in the middle of a run must clear everything with no done pulse.
        @(posedge clk); #1;
        i_start = 1'b1;
        i_n     = N_W'(12);
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_S", int'(o_s), 0);
        check("midrst_done", int'(o_done), 0);
        check("midrst_busy", int'(o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_op(6, 12, 1'b0);

        run_held(4, 3);
        run_op(1, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            n = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(n, closed_form(n), 1'b0);
        end

        for (int t = 0; t < 50 && exp_s.size() != 0; t++) @(posedge clk);
        check("scoreboard_drained", exp_s.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
